mem_port_arbiter: RTL

Shares one unified memory port between the pipelined core's instruction-fetch and data-access interfaces. Sits between the core (`inst_mem_req/rsp`, `data_mem_req/rsp`) and a single-ported `memory_io` memory. Each requester gets a one-entry request buffer, and the block keeps one transaction outstanding at a time. Data accesses have priority, with an anti-starvation counter for fetch.

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter (with mem_port_arbiter_pkg)
// Description : Shares one single-ported memory between the core's fetch and
//               data interfaces. Each requester has a one-entry request
//               buffer. Only one memory transaction is in flight at a time.
//               Data has priority, and a starvation counter forces a fetch
//               grant after STARVE_LIMIT consecutive data grants.
// Revision    : 1.0 - initial release
// ============================================================================

package mem_port_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  do_read;
        logic [3:0]  do_write;
    } memory_io_req;

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic [31:0] data;
    } memory_io_rsp;

    localparam memory_io_req memory_io_no_req = '0;

endpackage

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  memory_io_req inst_req,
    output memory_io_rsp inst_rsp,
    input  memory_io_req data_req,
    output memory_io_rsp data_rsp,
    output memory_io_req mem_req,
    input  memory_io_rsp mem_rsp,
    output logic         stray_rsp
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] c_STARVE_MAX   = 4'd15;

    state_t       r_state;
    state_t       w_state_next;

    logic         r_pend_i;
    logic         r_pend_d;
    memory_io_req r_buf_i;
    memory_io_req r_buf_d;

    logic [3:0]   r_starve_cnt;

    logic         r_irsp_valid;
    logic [31:0]  r_irsp_addr;
    logic [31:0]  r_irsp_data;
    logic         r_drsp_valid;
    logic [31:0]  r_drsp_addr;
    logic [31:0]  r_drsp_data;
    logic         r_stray;

    logic         w_pick_i;
    logic         w_grant_i;
    logic         w_grant_d;
    logic         w_done_i;
    logic         w_done_d;
    memory_io_req w_mem_req;

    // Fetch wins if it is the only one pending or data has starved it long enough
    assign w_pick_i = r_pend_i && (!r_pend_d || (r_starve_cnt >= c_STARVE_LIMIT));

    // Completion of the owning transaction, one per WAIT state
    assign w_done_i = (r_state == WAIT_I) && mem_rsp.valid;
    assign w_done_d = (r_state == WAIT_D) && mem_rsp.valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, grant decision and memory request drive
    always_comb begin
        w_state_next = r_state;
        w_mem_req    = memory_io_no_req;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_rsp.ready && (r_pend_i || r_pend_d)) begin
                    if (w_pick_i) begin
                        w_grant_i    = 1'b1;
                        w_mem_req    = r_buf_i;
                        w_state_next = WAIT_I;
                    end else begin
                        w_grant_d    = 1'b1;
                        w_mem_req    = r_buf_d;
                        w_state_next = WAIT_D;
                    end
                    w_mem_req.valid = 1'b1;
                end
            end
            WAIT_I: begin
                if (mem_rsp.valid) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rsp.valid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request buffers: capture while empty, release on the owner's completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_i <= 1'b0;
            r_pend_d <= 1'b0;
            r_buf_i  <= memory_io_no_req;
            r_buf_d  <= memory_io_no_req;
        end else begin
            if (inst_req.valid && !r_pend_i) begin
                r_pend_i <= 1'b1;
                r_buf_i  <= inst_req;
            end else if (w_done_i) begin
                r_pend_i <= 1'b0;
            end
            if (data_req.valid && !r_pend_d) begin
                r_pend_d <= 1'b1;
                r_buf_d  <= data_req;
            end else if (w_done_d) begin
                r_pend_d <= 1'b0;
            end
        end
    end

    // Count data grants that bypass a waiting fetch, saturating at 15
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= 4'd0;
        end else if (!r_pend_i || w_grant_i) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Registered responses: one-cycle valid to the owner only, stray flag otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irsp_valid <= 1'b0;
            r_irsp_addr  <= 32'd0;
            r_irsp_data  <= 32'd0;
            r_drsp_valid <= 1'b0;
            r_drsp_addr  <= 32'd0;
            r_drsp_data  <= 32'd0;
            r_stray      <= 1'b0;
        end else begin
            r_irsp_valid <= w_done_i;
            r_drsp_valid <= w_done_d;
            r_stray      <= (r_state == IDLE) && mem_rsp.valid;
            if (w_done_i) begin
                r_irsp_addr <= mem_rsp.addr;
                r_irsp_data <= mem_rsp.data;
            end
            if (w_done_d) begin
                r_drsp_addr <= mem_rsp.addr;
                r_drsp_data <= mem_rsp.data;
            end
        end
    end

    assign mem_req   = w_mem_req;
    assign stray_rsp = r_stray;

    assign inst_rsp.valid = r_irsp_valid;
    assign inst_rsp.ready = !r_pend_i;
    assign inst_rsp.addr  = r_irsp_addr;
    assign inst_rsp.data  = r_irsp_data;

    assign data_rsp.valid = r_drsp_valid;
    assign data_rsp.ready = !r_pend_d;
    assign data_rsp.addr  = r_drsp_addr;
    assign data_rsp.data  = r_drsp_data;

endmodule

`default_nettype wire
